fifo_consumer: RTL and testbench
================================

FIFO_CONSUMER -- requirements
Module: fifo_consumer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, FIFO word and RAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 20, RAM address width.
REQ-003 SHALL have parameter BURST_SIZE, default 4, maximum RAM writes per grant.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that launches a transfer.
REQ-007 SHALL have port done, output, 1, high from transfer completion until the next accepted start.
REQ-008 SHALL have ports addr_begin, addr_step and addr_end, inputs, ADDR_WIDTH each: first write address, positive step, and last legal address; all sampled on accepted start.
REQ-009 SHALL have port request, output, 1, RAM arbitration request.
REQ-010 SHALL have port grant, input, 1, RAM arbitration grant.
REQ-011 SHALL have port fifo_empty, input, 1, sync FIFO empty flag.
REQ-012 SHALL have port fifo_r_en, output, 1, FIFO pop.
REQ-013 SHALL have port fifo_data_out, input, DATA_WIDTH, FIFO read data, valid the cycle after fifo_r_en.
REQ-014 SHALL have ports to_buffer_cs, to_buffer_oe, to_buffer_W_req, outputs, 1 each: RAM chip select, output enable and write request, all active-high.
REQ-015 SHALL have ports to_buffer_addr (ADDR_WIDTH) and to_buffer_W_data (DATA_WIDTH), outputs: RAM write address and write data.

Function
REQ-016 SHALL implement states IDLE, REQ, BURST, GAP and DONE.
REQ-017 SHALL accept start only in IDLE or DONE, then latch addr_begin into the write-address register, clear done and enter REQ; start in any other state SHALL be ignored.
REQ-018 SHALL drive request=1 in REQ and BURST and 0 otherwise; REQ SHALL move to BURST on grant=1.
REQ-019 SHALL assert fifo_r_en only in BURST when all hold: grant=1, fifo_empty=0, pops in this burst < BURST_SIZE, no pop has yet fetched the final word, and (skid occupancy + pops in flight - write this cycle) < 2.
REQ-020 SHALL capture fifo_data_out into a 2-entry skid buffer one cycle after each pop.
REQ-021 SHALL write the oldest skid entry whenever it is non-empty and grant=1: to_buffer_cs=1, to_buffer_W_req=1, to_buffer_oe=0, to_buffer_addr = current address, to_buffer_W_data = entry. With grant continuously high, latency from pop to write SHALL be 2 cycles, at a throughput of 1 word/cycle.
REQ-022 SHALL advance the address by addr_step after each write using an ADDR_WIDTH+1 bit sum; the word just written SHALL be final if the sum exceeds addr_end or carries out of ADDR_WIDTH (no wrap-around).
REQ-023 SHALL leave BURST for GAP when BURST_SIZE writes have completed in the burst and the final word has not been written; GAP SHALL hold request=0 for exactly one cycle, then enter REQ.
REQ-024 SHALL enter DONE and assert done the cycle after the final write, in place of GAP.
REQ-025 SHALL, on fifo_empty=1 in BURST, stay in BURST with request held and resume popping when the FIFO refills.
REQ-026 SHALL, on grant=0 in BURST, issue no pops and no writes, retain skid contents and in-flight data, and resume on grant=1.
REQ-027 SHALL drive to_buffer_cs=0, to_buffer_W_req=0, to_buffer_oe=0 and to_buffer_W_data=0 in non-write cycles.
REQ-028 SHALL, when addr_begin > addr_end at start, enter DONE directly with no pops and no writes.

Reset
REQ-029 SHALL, while rstn=0, asynchronously force IDLE, clear the skid buffer, counters and address register, and drive done, request, fifo_r_en and all RAM outputs to 0.
REQ-030 SHALL abandon any transfer on reset mid-operation; data in flight is discarded.

Configuration
REQ-031 SHALL, with macro FIFO_CONSUMER_WCOUNT_EN defined, provide a 32-bit output word_count that clears on accepted start and increments on each RAM write.
REQ-032 SHALL, without FIFO_CONSUMER_WCOUNT_EN, tie word_count to 0 and synthesise no counter.

Verification
REQ-033 Case: begin=0, step=1, end=7, BURST_SIZE=4, grant always 1, FIFO holding 8 words -> writes to addresses 0-7 in order, a one-cycle request gap after address 3, done=1 the cycle after the write to 7.
REQ-034 Case: begin=0x10, step=4, end=0x1C -> writes only to 0x10, 0x14, 0x18 and 0x1C; exactly 4 pops.
REQ-035 Case: grant drops for 3 cycles while both skid entries are full -> no writes during the drop, no data lost, order preserved after grant returns.
REQ-036 Case: FIFO empties after 2 words mid-burst, refills 5 cycles later -> request stays 1, writes resume at the next address.
REQ-037 Case: begin=0xFFFFE, step=2, end=0xFFFFF -> one write to 0xFFFFE, then done (carry detected, no wrap to 0).
REQ-038 Case: rstn=0 mid-burst, then start -> all outputs 0 during reset; the new transfer begins at the new addr_begin.

Source files
------------

// File: rtl/fifo_consumer_if.sv
// FIFO-read and RAM-write bus of fifo_consumer: master is the consumer,
// slave is the FIFO/RAM/arbiter side.
interface fifo_consumer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20
);
  logic                  request;
  logic                  grant;
  logic                  fifo_empty;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic                  to_buffer_cs;
  logic                  to_buffer_oe;
  logic                  to_buffer_W_req;
  logic [ADDR_WIDTH-1:0] to_buffer_addr;
  logic [DATA_WIDTH-1:0] to_buffer_W_data;

  modport master (
    output request, fifo_r_en, to_buffer_cs, to_buffer_oe, to_buffer_W_req,
           to_buffer_addr, to_buffer_W_data,
    input  grant, fifo_empty, fifo_data_out
  );

  modport slave (
    input  request, fifo_r_en, to_buffer_cs, to_buffer_oe, to_buffer_W_req,
           to_buffer_addr, to_buffer_W_data,
    output grant, fifo_empty, fifo_data_out
  );
endinterface

// File: rtl/fifo_consumer.sv
// Drains a sync FIFO into RAM in granted bursts over an address range.
// Optional 32-bit write counter on word_count when FIFO_CONSUMER_WCOUNT_EN is defined.
module fifo_consumer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20,
  parameter int BURST_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] addr_begin,
  input  logic [ADDR_WIDTH-1:0] addr_step,
  input  logic [ADDR_WIDTH-1:0] addr_end,
  output logic [31:0]           word_count,
  fifo_consumer_if.master       bus
);
  localparam int CW = $clog2(BURST_SIZE + 1);

  typedef enum logic [2:0] {IDLE, REQ, BURST, GAP, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] wr_addr, pop_addr, step_q, end_q;
  logic [DATA_WIDTH-1:0] skid0, skid1;
  logic [1:0]            skid_cnt;
  logic                  in_flight, popped_final;
  logic [CW-1:0]         pop_cnt, wr_cnt;
  logic [ADDR_WIDTH:0]   wr_sum, pop_sum;
  logic [2:0]            occ_after;
  logic                  start_ok, pop, wr, wr_final, pop_final;

  // pop_addr runs ahead of wr_addr so the last needed pop is known without dividing the range
  assign start_ok  = start && (state == IDLE || state == DONE);
  assign wr_sum    = {1'b0, wr_addr} + {1'b0, step_q};
  assign pop_sum   = {1'b0, pop_addr} + {1'b0, step_q};
  assign wr_final  = wr_sum[ADDR_WIDTH] || (wr_sum > {1'b0, end_q});
  assign pop_final = pop_sum[ADDR_WIDTH] || (pop_sum > {1'b0, end_q});
  assign wr        = (state == BURST) && bus.grant && (skid_cnt != 2'd0);
  assign occ_after = {1'b0, skid_cnt} + {2'b00, in_flight} - {2'b00, wr};
  assign pop       = (state == BURST) && bus.grant && !bus.fifo_empty &&
                     (pop_cnt < CW'(BURST_SIZE)) && !popped_final && (occ_after < 3'd2);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (addr_begin > addr_end) ? DONE : REQ;
      REQ:        if (bus.grant) state_nxt = BURST;
      BURST: begin
        if (wr && wr_final)                          state_nxt = DONE;
        else if (wr && wr_cnt == CW'(BURST_SIZE - 1)) state_nxt = GAP;
      end
      GAP:        state_nxt = REQ;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done                 = (state == DONE);
    bus.request          = (state == REQ) || (state == BURST);
    bus.fifo_r_en        = pop;
    bus.to_buffer_cs     = wr;
    bus.to_buffer_W_req  = wr;
    bus.to_buffer_oe     = 1'b0;
    bus.to_buffer_addr   = wr ? wr_addr : '0;
    bus.to_buffer_W_data = wr ? skid0 : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_addr      <= '0;
      pop_addr     <= '0;
      step_q       <= '0;
      end_q        <= '0;
      popped_final <= 1'b0;
      pop_cnt      <= '0;
      wr_cnt       <= '0;
    end else begin
      if (start_ok) begin
        wr_addr      <= addr_begin;
        pop_addr     <= addr_begin;
        step_q       <= addr_step;
        end_q        <= addr_end;
        popped_final <= 1'b0;
      end else begin
        if (wr) wr_addr <= wr_sum[ADDR_WIDTH-1:0];
        if (pop) begin
          pop_addr <= pop_sum[ADDR_WIDTH-1:0];
          if (pop_final) popped_final <= 1'b1;
        end
      end
      if (state != BURST) begin
        pop_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        if (pop) pop_cnt <= pop_cnt + CW'(1);
        if (wr)  wr_cnt  <= wr_cnt + CW'(1);
      end
    end
  end

  // skid0 is always the oldest entry; data arrives one cycle after its pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skid0     <= '0;
      skid1     <= '0;
      skid_cnt  <= 2'd0;
      in_flight <= 1'b0;
    end else begin
      in_flight <= pop;
      case ({in_flight, wr})
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= bus.fifo_data_out;
          else                  skid1 <= bus.fifo_data_out;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) skid0 <= bus.fifo_data_out;
          else begin
            skid0 <= skid1;
            skid1 <= bus.fifo_data_out;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_CONSUMER_WCOUNT_EN
  logic [31:0] wcount;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         wcount <= '0;
    else if (start_ok) wcount <= '0;
    else if (wr)       wcount <= wcount + 32'd1;
  end

  assign word_count = wcount;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_consumer.sv
// Scoreboard bench for fifo_consumer: FIFO model, address-range reference model,
// directed corner cases followed by randomized transfers with random grant drops.
module tb_fifo_consumer;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int BS = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          done;
  logic [AW-1:0] addr_begin = '0;
  logic [AW-1:0] addr_step = '0;
  logic [AW-1:0] addr_end = '0;
  logic [31:0]   word_count;

  fifo_consumer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_consumer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_SIZE(BS)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .done       (done),
    .addr_begin (addr_begin),
    .addr_step  (addr_step),
    .addr_end   (addr_end),
    .word_count (word_count),
    .bus        (bus)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  int            pop_cyc_q[$];
  int            exp_n = 0;

  logic [DW-1:0] mem[1024];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          flush = 1'b0;

  int   cyc = 0;
  int   last_wr_cyc = -10;
  int   last_glow_cyc = -1;
  int   writes_in_xfer = 0;
  int   pops_in_xfer = 0;
  int   burst_writes = 0;
  logic prev_req = 1'b0;
  logic prev_done = 1'b0;
  logic gap_pending = 1'b0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Synchronous FIFO model: read data appears the cycle after fifo_r_en
  initial begin
    bus.fifo_data_out = '0;
    forever begin
      @(posedge clk);
      if (flush) rd_ptr <= wr_ptr;
      else if (bus.fifo_r_en && rd_ptr != wr_ptr) begin
        bus.fifo_data_out <= mem[rd_ptr % 1024];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // Monitor: pops expected writes from the scoreboard whenever the RAM bus is active
  initial begin : monitor
    int pc;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        checkOutput("reset_ctrl", 64'({done, bus.request, bus.fifo_r_en, bus.to_buffer_cs,
                                       bus.to_buffer_oe, bus.to_buffer_W_req}), 64'(0));
        checkOutput("reset_bus", 64'({bus.to_buffer_addr, bus.to_buffer_W_data}), 64'(0));
        pop_cyc_q.delete();
        prev_req = 1'b0;
        prev_done = 1'b0;
        gap_pending = 1'b0;
        burst_writes = 0;
      end else begin
        if (start) begin
          writes_in_xfer = 0;
          pops_in_xfer = 0;
        end
        if (!bus.grant) last_glow_cyc = cyc;
        if (gap_pending) begin
          checkOutput("gap_len", 64'(bus.request), 64'(1));
          gap_pending = 1'b0;
        end
        if (bus.fifo_r_en) begin
          checkOutput("pop_cond", 64'({bus.grant, bus.fifo_empty}), 64'(2'b10));
          pops_in_xfer++;
          pop_cyc_q.push_back(cyc);
        end
        if (bus.to_buffer_cs) begin
          checkOutput("wr_ctrl", 64'({bus.grant, bus.to_buffer_W_req, bus.to_buffer_oe}), 64'(3'b110));
          if (exp_addr_q.size() == 0 || exp_data_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL wr_unexpected: write addr %0h data %0h, want no write",
                     bus.to_buffer_addr, bus.to_buffer_W_data);
          end else begin
            checkOutput("wr_addr", 64'(bus.to_buffer_addr), 64'(exp_addr_q.pop_front()));
            checkOutput("wr_data", 64'(bus.to_buffer_W_data), 64'(exp_data_q.pop_front()));
          end
          if (pop_cyc_q.size() > 0) begin
            pc = pop_cyc_q.pop_front();
            if (last_glow_cyc < pc) checkOutput("wr_latency", 64'(cyc - pc), 64'(2));
          end
          writes_in_xfer++;
          burst_writes++;
          last_wr_cyc = cyc;
        end else begin
          checkOutput("idle_bus", 64'({bus.to_buffer_W_req, bus.to_buffer_oe, bus.to_buffer_W_data}), 64'(0));
        end
        if (prev_req && !bus.request) begin
          if (done) checkOutput("last_burst_len", 64'(burst_writes <= BS), 64'(1));
          else begin
            checkOutput("burst_len", 64'(burst_writes), 64'(BS));
            gap_pending = 1'b1;
          end
          burst_writes = 0;
        end
        if (!prev_done && done && writes_in_xfer > 0)
          checkOutput("done_timing", 64'(cyc), 64'(last_wr_cyc + 1));
        prev_req = bus.request;
        prev_done = done;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord();
    logic [DW-1:0] w;
    w = DW'($urandom);
    mem[wr_ptr % 1024] = w;
    wr_ptr++;
    exp_data_q.push_back(w);
  endtask

  // Reference model: one write per address begin + k*step up to end, never past 2^AW
  task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [AW-1:0] e);
    longint a;
    a = longint'(b);
    exp_n = 0;
    while (a <= longint'(e) && a < (longint'(1) << AW)) begin
      exp_addr_q.push_back(a[AW-1:0]);
      exp_n++;
      a += longint'(s);
    end
    addr_begin = b;
    addr_step = s;
    addr_end = e;
    start = 1'b1;
    tick();
    start = 1'b0;
    addr_begin = AW'($urandom);
    addr_step = AW'($urandom);
    addr_end = AW'($urandom);
    tick();
    checkOutput("start_accept", 64'({done, bus.request}), (exp_n == 0) ? 64'(2'b10) : 64'(2'b01));
  endtask

  task automatic runUntilDone(input int words_left, input bit rnd_grant, input int budget);
    int n;
    int left;
    n = 0;
    left = words_left;
    while (!done && n < budget) begin
      if (left > 0 && $urandom_range(0, 1) == 1) begin
        pushWord();
        left--;
      end
      if (rnd_grant) bus.grant = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    bus.grant = 1'b1;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: done=%0b after %0d cycles, want 1", done, n);
    end else begin
      checkOutput("xfer_pops", 64'(pops_in_xfer), 64'(exp_n));
      checkOutput("xfer_writes", 64'(writes_in_xfer), 64'(exp_n));
      checkOutput("xfer_addr_left", 64'(exp_addr_q.size()), 64'(0));
`ifdef FIFO_CONSUMER_WCOUNT_EN
      checkOutput("word_count", 64'(word_count), 64'(exp_n));
`else
      checkOutput("word_count", 64'(word_count), 64'(0));
`endif
    end
    exp_addr_q.delete();
  endtask

  task automatic waitWrites(input int n, input int budget);
    int k;
    k = 0;
    while (writes_in_xfer < n && k < budget) begin
      tick();
      k++;
    end
    if (writes_in_xfer < n) begin
      total++;
      bad++;
      $display("[TB] FAIL write_wait: writes=%0d, want %0d", writes_in_xfer, n);
    end
  endtask

  initial begin : stimulus
    int k;
    int s;
    int n;
    int b;
    int e;
    bus.grant = 1'b1;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    checkOutput("idle_after_reset", 64'({done, bus.request, bus.fifo_r_en}), 64'(0));

    // Contiguous range over two bursts
    repeat (8) pushWord();
    applyStimulus(20'h0, 20'h1, 20'h7);
    runUntilDone(0, 1'b0, 200);

    // Stride 4: exactly four pops, two words stay in the FIFO
    repeat (6) pushWord();
    applyStimulus(20'h10, 20'h4, 20'h1C);
    runUntilDone(0, 1'b0, 200);

    // Grant withdrawn for 3 cycles mid-burst
    repeat (12) pushWord();
    applyStimulus(20'h100, 20'h1, 20'h10B);
    waitWrites(2, 100);
    bus.grant = 1'b0;
    repeat (3) tick();
    bus.grant = 1'b1;
    runUntilDone(0, 1'b0, 200);

    // FIFO holds two words, runs dry, refills five cycles later
    applyStimulus(20'h200, 20'h3, 20'h215);
    k = 0;
    while (!(bus.fifo_empty && pops_in_xfer >= 2) && k < 100) begin
      tick();
      k++;
    end
    repeat (5) begin
      tick();
      checkOutput("hold_request", 64'(bus.request), 64'(1));
    end
    repeat (6) pushWord();
    runUntilDone(0, 1'b0, 200);

    // Top of address space: carry ends the transfer after one write
    repeat (2) pushWord();
    applyStimulus(20'hFFFFE, 20'h2, 20'hFFFFF);
    runUntilDone(0, 1'b0, 200);

    // Empty range: straight to done with nothing popped
    applyStimulus(20'h50, 20'h1, 20'h40);
    runUntilDone(0, 1'b0, 10);

    // Reset mid-burst, then a fresh transfer
    repeat (40) pushWord();
    applyStimulus(20'h0, 20'h1, 20'd39);
    waitWrites(5, 100);
    rstn = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (2) tick();
    exp_addr_q.delete();
    exp_data_q.delete();
    rstn = 1'b1;
    tick();
    checkOutput("post_reset", 64'({done, bus.request}), 64'(0));
    repeat (8) pushWord();
    applyStimulus(20'h300, 20'h2, 20'h30E);
    runUntilDone(0, 1'b0, 200);

    // Randomized ranges, FIFO fill timing and grant drops
    for (int t = 0; t < 10; t++) begin
      s = $urandom_range(1, 5);
      n = $urandom_range(1, 12);
      b = (t == 9) ? (32'hFFFFF - $urandom_range(0, 20)) : $urandom_range(0, 32'h3FF);
      e = (t == 9) ? 32'hFFFFF : (b + (n - 1) * s + $urandom_range(0, s - 1));
      applyStimulus(AW'(b), AW'(s), AW'(e));
      runUntilDone(exp_n, 1'b1, 2000);
    end

    repeat (5) tick();
    checkOutput("data_left", 64'(exp_data_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
